mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Memory stage of the 5-stage RV32I pipeline, fed directly by the EX/MEM register.
//  Turns M-stage load/store controls into a req/gnt/rvalid data-memory transaction.
//  Aligns store data and generates byte enables; extracts and sign/zero-extends load data.
//  Stalls the pipeline while a load is outstanding; owns the MEM/WB register.
// PARAMETERS
//  DATA_WIDTH  32  datapath/address width (only 32 supported)
//  WIDTH       5   register index width
// PORTS
//  clk            in   1   clock
//  rst            in   1   asynchronous active-high reset
//  RegWriteM      in   1   register-file write enable of M instr
//  ResultSrcM     in   2   result mux select, passed to W
//  MemWriteM      in   1   store
//  MemReadM       in   1   load
//  modeAddrM      in   3   funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResultM     in   32  effective address / ALU result
//  WriteDataM     in   32  store data (rs2)
//  RdM            in   5   destination register
//  PCPlus4M       in   32  link value
//  StallM         out  1   hold F/D/E/M stages (comb)
//  dmem_req       out  1   request valid (comb)
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  {ALUResultM[31:2],2'b00}
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-aligned store data
//  dmem_gnt       in   1   request accepted this cycle
//  dmem_rvalid    in   1   read data valid (>=1 cycle after gnt)
//  dmem_rdata     in   32  read word
//  RegWriteW, ResultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W  out  registered W-stage copies
// BEHAVIOUR
//  - Reset: state IDLE; all W outputs 0; StallM=0, dmem_req=0.
//  - FSM IDLE/WAIT_R. IDLE: dmem_req=MemReadM|MemWriteM. Store+gnt -> done, no stall.
//    Store without gnt -> StallM=1, stay IDLE (request held). Load+gnt -> WAIT_R.
//    Load without gnt -> stay IDLE. Load in IDLE always stalls.
//  - WAIT_R: dmem_req=0; StallM=~dmem_rvalid; on rvalid capture load result, go IDLE.
//  - MemReadM and MemWriteM both high: treated as store.
//  - dmem_be/wdata: B -> 0001<<a[1:0], data replicated per byte; H -> 0011<<{a[1],0},
//    halfword replicated; W -> 1111. Loads: dmem_be=1111, dmem_we=0.
//  - Load extract: select byte/half by a[1:0]/a[1]; B/H sign-extend, BU/HU zero-extend.
//  - MEM/WB register: updates every clk. When StallM=1 a bubble is written
//    (RegWriteW=0, others don't care); otherwise all M fields are copied.
//    ReadDataW = extracted load data on completion.
//  - Min load cost 1 stall cycle (gnt cycle); each extra rvalid delay adds 1.
//  - rvalid in IDLE is ignored. Reset mid-load: FSM to IDLE, late rvalid ignored.
//  - Non-memory instr: no request, no stall, straight to W.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with a[0]=1 or W with a[1:0]!=0 suppresses dmem_req.
//  No stall occurs; bubble to W (RegWriteW=0); extra out port misalign_o (1 cycle, comb).
//  Undefined: low address bits ignored for H (a[0]) and W (a[1:0]); the access is
//  performed at the aligned location; no port.
// STRUCTURE
//  Package riscv_mem_pkg: typedef enum logic[2:0] mem_mode_t (MODE_B/H/W/BU/HU),
//  typedef enum logic lsu_state_t (IDLE, WAIT_R), function be_for(mode,addr).
//  Sub-module lsu_align: combinational store lane-shift + load extract/extend.
// TESTING
//  SW 0xDEADBEEF @0x100, gnt=1 -> be=1111, wdata=0xDEADBEEF, StallM=0 throughout.
//  SB 0x000000AB @0x103 -> be=1000, wdata=0xABABABAB.
//  LB @0x102, rdata=0x0080FF00, rvalid 1 cycle after gnt -> StallM 1 cycle, ReadDataW=0xFFFFFF80.
//  LHU @0x102, rdata=0x8001xxxx -> ReadDataW=0x00008001.
//  LW with gnt delayed 2 cycles, rvalid 3 cycles later -> StallM high 5 cycles, req 3 cycles, RegWriteW once.
//  rst asserted in WAIT_R, then stray rvalid -> all outputs 0, no W write.
//  MISALIGN_TRAP_EN: LW @0x101 -> dmem_req=0, misalign_o=1, RegWriteW=0.
//  Without MISALIGN_TRAP_EN: LW @0x101 -> dmem_addr=0x100.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the M-stage load/store unit.
package riscv_mem_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned BE_W = XLEN / 8;

    // funct3 encodings of the RV32I load/store width field
    typedef enum logic [2:0] {
        MODE_B  = 3'b000,
        MODE_H  = 3'b001,
        MODE_W  = 3'b010,
        MODE_BU = 3'b100,
        MODE_HU = 3'b101
    } mem_mode_t;

    typedef enum logic {
        IDLE   = 1'b0,
        WAIT_R = 1'b1
    } lsu_state_t;

    // Byte enables of a store; low address bits below the access size are ignored
    function automatic logic [BE_W-1:0] be_for(input mem_mode_t mode, input logic [1:0] addr);
        logic [BE_W-1:0] be;
        case (mode)
            MODE_B, MODE_BU: be = 4'b0001 << addr;
            MODE_H, MODE_HU: be = 4'b0011 << {addr[1], 1'b0};
            default:         be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory req/gnt/rvalid channel between the LSU (master) and memory (slave).
interface mem_stage_lsu_if;

    logic                              req;
    logic                              we;
    logic [riscv_mem_pkg::XLEN-1:0]    addr;
    logic [riscv_mem_pkg::BE_W-1:0]    be;
    logic [riscv_mem_pkg::XLEN-1:0]    wdata;
    logic                              gnt;
    logic                              rvalid;
    logic [riscv_mem_pkg::XLEN-1:0]    rdata;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata
    );

endinterface

// File: rtl/mem_stage_lsu_align.sv
// Store lane replication and load byte/half extraction with sign/zero extension.
module lsu_align
    import riscv_mem_pkg::*;
(
    input  mem_mode_t       i_mode,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_store_data,
    input  logic [XLEN-1:0] i_load_word,
    output logic [XLEN-1:0] o_store_data,
    output logic [XLEN-1:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Replicate the store operand across every lane; byte enables pick the live one
    always_comb begin
        o_store_data = i_store_data;
        case (i_mode)
            MODE_B, MODE_BU: o_store_data = {4{i_store_data[7:0]}};
            MODE_H, MODE_HU: o_store_data = {2{i_store_data[15:0]}};
            default:         o_store_data = i_store_data;
        endcase
    end

    // Pick the addressed byte/half from the returned word and extend it
    always_comb begin
        w_byte = i_load_word[7:0];
        case (i_addr_lo)
            2'd0:    w_byte = i_load_word[7:0];
            2'd1:    w_byte = i_load_word[15:8];
            2'd2:    w_byte = i_load_word[23:16];
            default: w_byte = i_load_word[31:24];
        endcase
        w_half = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

        o_load_data = i_load_word;
        case (i_mode)
            MODE_B:  o_load_data = {{24{w_byte[7]}}, w_byte};
            MODE_BU: o_load_data = {24'd0, w_byte};
            MODE_H:  o_load_data = {{16{w_half[15]}}, w_half};
            MODE_HU: o_load_data = {16'd0, w_half};
            default: o_load_data = i_load_word;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// RV32I memory stage: drives the data-memory channel, stalls on outstanding
// loads and owns the MEM/WB register.
// Build option: MISALIGN_TRAP_EN - misaligned H/W accesses are suppressed,
// turned into a W bubble and flagged on misalign_o; otherwise the low address
// bits are ignored and the aligned location is accessed.
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WIDTH      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWriteM,
    input  logic [1:0]            ResultSrcM,
    input  logic                  MemWriteM,
    input  logic                  MemReadM,
    input  logic [2:0]            modeAddrM,
    input  logic [DATA_WIDTH-1:0] ALUResultM,
    input  logic [DATA_WIDTH-1:0] WriteDataM,
    input  logic [WIDTH-1:0]      RdM,
    input  logic [DATA_WIDTH-1:0] PCPlus4M,
    output logic                  StallM,
    mem_stage_lsu_if.master       dmem,
`ifdef MISALIGN_TRAP_EN
    output logic                  misalign_o,
`endif
    output logic                  RegWriteW,
    output logic [1:0]            ResultSrcW,
    output logic [WIDTH-1:0]      RdW,
    output logic [DATA_WIDTH-1:0] ALUResultW,
    output logic [DATA_WIDTH-1:0] ReadDataW,
    output logic [DATA_WIDTH-1:0] PCPlus4W
);

    lsu_state_t      r_state;
    lsu_state_t      w_state_next;
    mem_mode_t       w_mode;
    logic            w_is_store;
    logic            w_mem_op;
    logic            w_misalign;
    logic            w_req;
    logic            w_load_done;
    logic [XLEN-1:0] w_store_data;
    logic [XLEN-1:0] w_load_data;

    assign w_mode     = mem_mode_t'(modeAddrM);
    assign w_is_store = MemWriteM;
    assign w_mem_op   = MemReadM | MemWriteM;

`ifdef MISALIGN_TRAP_EN
    // Only a new access in IDLE can be misaligned; a granted load is already committed
    always_comb begin
        w_misalign = 1'b0;
        if (w_mem_op && r_state == IDLE) begin
            case (w_mode)
                MODE_H, MODE_HU: w_misalign = ALUResultM[0];
                MODE_W:          w_misalign = |ALUResultM[1:0];
                default:         w_misalign = 1'b0;
            endcase
        end
    end
    assign misalign_o = w_misalign;
`else
    assign w_misalign = 1'b0;
`endif

    lsu_align u_align (
        .i_mode       (w_mode),
        .i_addr_lo    (ALUResultM[1:0]),
        .i_store_data (WriteDataM),
        .i_load_word  (dmem.rdata),
        .o_store_data (w_store_data),
        .o_load_data  (w_load_data)
    );

    // Request/stall control; a store completes on gnt, a load waits for rvalid
    always_comb begin
        w_state_next = r_state;
        StallM       = 1'b0;
        w_req        = 1'b0;
        w_load_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op && !w_misalign) begin
                    w_req = 1'b1;
                    if (w_is_store) begin
                        StallM = ~dmem.gnt;
                    end else begin
                        StallM = 1'b1;
                        if (dmem.gnt) w_state_next = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                StallM = ~dmem.rvalid;
                if (dmem.rvalid) begin
                    w_load_done  = 1'b1;
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign dmem.req   = w_req;
    assign dmem.we    = w_is_store;
    assign dmem.addr  = {ALUResultM[DATA_WIDTH-1:2], 2'b00};
    assign dmem.be    = w_is_store ? be_for(w_mode, ALUResultM[1:0]) : 4'b1111;
    assign dmem.wdata = w_store_data;

    // FSM state register; reset abandons any outstanding load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    // MEM/WB register: zero bubble while stalled or trapped, else copy M
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'd0;
            RdW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
        end else if (StallM || w_misalign) begin
            RegWriteW  <= 1'b0;
            ResultSrcW <= 2'd0;
            RdW        <= '0;
            ALUResultW <= '0;
            ReadDataW  <= '0;
            PCPlus4W   <= '0;
        end else begin
            RegWriteW  <= RegWriteM;
            ResultSrcW <= ResultSrcM;
            RdW        <= RdM;
            ALUResultW <= ALUResultM;
            ReadDataW  <= w_load_done ? w_load_data : '0;
            PCPlus4W   <= PCPlus4M;
        end
    end

endmodule
